// File: rtl/resumption_delay_loop_if.sv
// Stream interface for resumption_delay_loop: input word, registered output word, live flag.
// The __steps counter output exists only when REWIRE_STEP_COUNT_EN is defined.
interface resumption_delay_loop_if #(
    parameter int unsigned WIDTH = 8
`ifdef REWIRE_STEP_COUNT_EN
    , parameter int unsigned CNT_W = 16
`endif
);
    logic [WIDTH-1:0] __in0;
    logic [WIDTH-1:0] __out0;
    logic             __continue;
`ifdef REWIRE_STEP_COUNT_EN
    logic [CNT_W-1:0] __steps;
`endif

    // master is the stream source, slave is the resumption machine
    modport master (
        output __in0,
        input  __out0,
        input  __continue
`ifdef REWIRE_STEP_COUNT_EN
        , input __steps
`endif
    );

    modport slave (
        input  __in0,
        output __out0,
        output __continue
`ifdef REWIRE_STEP_COUNT_EN
        , output __steps
`endif
    );
endinterface

// File: rtl/resumption_delay_loop.sv
// Three-state resumption machine emitting in ^ in[DEPTH steps ago] until TERM is seen.
// Optional saturating LOOP-step counter enabled by defining REWIRE_STEP_COUNT_EN.
module resumption_delay_loop #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] TERM  = 'hFF
`ifdef REWIRE_STEP_COUNT_EN
    , parameter int unsigned    CNT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    resumption_delay_loop_if.slave  io
);
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_LOOP  = 2'd1,
        S_HALT  = 2'd2
    } tag_e;

    tag_e             resumption_tag_q, resumption_tag_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic             continue_q, continue_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
`ifdef REWIRE_STEP_COUNT_EN
    logic [CNT_W-1:0] steps_q, steps_d;
`endif

    always_comb begin
        resumption_tag_d = resumption_tag_q;
        out0_d           = out0_q;
        continue_d       = continue_q;
        d_d              = d_q;
`ifdef REWIRE_STEP_COUNT_EN
        steps_d          = steps_q;
`endif
        case (resumption_tag_q)
            S_START: begin
                out0_d           = '0;
                continue_d       = 1'b1;
                resumption_tag_d = S_LOOP;
            end
            S_LOOP: begin
                out0_d = io.__in0 ^ d_q[DEPTH-1];
                d_d[0] = io.__in0;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    d_d[k] = d_q[k-1];
                end
`ifdef REWIRE_STEP_COUNT_EN
                if (steps_q != '1) begin
                    steps_d = steps_q + 1'b1;
                end
`endif
                // terminator still produces its output word and shift on this edge
                if (io.__in0 == TERM) begin
                    continue_d       = 1'b0;
                    resumption_tag_d = S_HALT;
                end else begin
                    continue_d       = 1'b1;
                end
            end
            S_HALT: begin
                continue_d = 1'b0;
            end
            default: begin
                continue_d       = 1'b0;
                resumption_tag_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resumption_tag_q <= S_START;
            out0_q           <= '0;
            continue_q       <= 1'b0;
            d_q              <= '{default: '0};
`ifdef REWIRE_STEP_COUNT_EN
            steps_q          <= '0;
`endif
        end else begin
            resumption_tag_q <= resumption_tag_d;
            out0_q           <= out0_d;
            continue_q       <= continue_d;
            d_q              <= d_d;
`ifdef REWIRE_STEP_COUNT_EN
            steps_q          <= steps_d;
`endif
        end
    end

    assign io.__out0     = out0_q;
    assign io.__continue = continue_q;
`ifdef REWIRE_STEP_COUNT_EN
    assign io.__steps    = steps_q;
`endif
endmodule

// File: tb/tb_resumption_delay_loop.sv
// Directed bench: DEPTH=2 instance driven from a vector table, DEPTH=1 instance by hand.
// Counter checks (CNT_W=2) are compiled only when REWIRE_STEP_COUNT_EN is defined.
module tb_resumption_delay_loop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef REWIRE_STEP_COUNT_EN
    resumption_delay_loop_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
    resumption_delay_loop_if #(.WIDTH(8), .CNT_W(2)) bus1 ();
    resumption_delay_loop #(.WIDTH(8), .DEPTH(2), .TERM(8'hFF), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .io(bus2));
    resumption_delay_loop #(.WIDTH(8), .DEPTH(1), .TERM(8'hFF), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .io(bus1));
`else
    resumption_delay_loop_if #(.WIDTH(8)) bus2 ();
    resumption_delay_loop_if #(.WIDTH(8)) bus1 ();
    resumption_delay_loop #(.WIDTH(8), .DEPTH(2), .TERM(8'hFF)) dut2 (
        .clk(clk), .rst(rst), .io(bus2));
    resumption_delay_loop #(.WIDTH(8), .DEPTH(1), .TERM(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .io(bus1));
`endif

    typedef struct {
        logic       rst;
        logic [7:0] in;
        logic [7:0] exp_out;
        logic       exp_cont;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // apply inputs, take one edge, sample 1 time unit later
    task automatic step(input logic r, input logic [7:0] in2, input logic [7:0] in1);
        rst       = r;
        bus2.__in0 = in2;
        bus1.__in0 = in1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus2.__in0 = '0;
        bus1.__in0 = '0;

        vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'hAA, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'h01, 8'h01, 1'b1};
        vecs[3]  = '{1'b0, 8'h02, 8'h02, 1'b1};
        vecs[4]  = '{1'b0, 8'h03, 8'h02, 1'b1};
        vecs[5]  = '{1'b0, 8'hFF, 8'hFD, 1'b0};
        vecs[6]  = '{1'b0, 8'h55, 8'hFD, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'hFD, 1'b0};
        vecs[8]  = '{1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 8'h05, 8'h05, 1'b1};
        vecs[11] = '{1'b0, 8'h10, 8'h10, 1'b1};
        vecs[12] = '{1'b0, 8'h07, 8'h02, 1'b1};
        vecs[13] = '{1'b1, 8'h33, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 8'h44, 8'h00, 1'b1};
        vecs[15] = '{1'b0, 8'h05, 8'h05, 1'b1};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].in, vecs[i].in);
            check($sformatf("vec%0d_out0", i), {24'h0, bus2.__out0}, {24'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_continue", i), {31'h0, bus2.__continue}, {31'h0, vecs[i].exp_cont});
        end

        // DEPTH=1: output is current input XOR previous input
        step(1'b1, 8'h00, 8'h00);
        check("d1_reset_out0", {24'h0, bus1.__out0}, 32'h00);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_reset", {30'h0, bus2.__steps}, 32'd0);
`endif
        step(1'b0, 8'h00, 8'h00);
        check("d1_start_cont", {31'h0, bus1.__continue}, 32'd1);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_start", {30'h0, bus2.__steps}, 32'd0);
`endif
        step(1'b0, 8'h11, 8'h0A);
        check("d1_out0_0A", {24'h0, bus1.__out0}, 32'h0A);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_1", {30'h0, bus2.__steps}, 32'd1);
`endif
        step(1'b0, 8'h22, 8'h0B);
        check("d1_out0_01", {24'h0, bus1.__out0}, 32'h01);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_2", {30'h0, bus2.__steps}, 32'd2);
`endif
        step(1'b0, 8'h33, 8'hFF);
        check("d1_term_out0", {24'h0, bus1.__out0}, 32'hF4);
        check("d1_term_cont", {31'h0, bus1.__continue}, 32'd0);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_3", {30'h0, bus2.__steps}, 32'd3);
`endif
        step(1'b0, 8'h44, 8'h12);
        check("d1_halt_out0", {24'h0, bus1.__out0}, 32'hF4);
        check("d1_halt_cont", {31'h0, bus1.__continue}, 32'd0);
`ifdef REWIRE_STEP_COUNT_EN
        check("steps_sat", {30'h0, bus2.__steps}, 32'd3);
`endif
        // DEPTH=2 instance: 44 ^ d[1]=22 -> 66, still live
        check("d2_out0_66", {24'h0, bus2.__out0}, 32'h66);
        check("d2_cont_live", {31'h0, bus2.__continue}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
